// File: rtl/seq_divider.sv
// Sequential restoring radix-2 divider for DIV/DIVU.
// One quotient bit per cycle; the fixed latency is 33 cycles from accepted start to done.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Two's-complement negate when the condition is set
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic c);
    return c ? (~x + ONE) : x;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out at the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic             sa_q, sa_d;     // dividend negative (signed op only)
  logic             sb_q, sb_d;     // divisor negative (signed op only)
  logic             zero_q, zero_d; // divisor was zero
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;

  // Next-state, datapath step and result fix-up
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zero_d  = zero_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, dvs_q};
    unique case (state_q)
      IDLE: begin
        // Start coinciding with the done pulse is dropped so results are never overrun.
        if (start && !done_q) begin
          sa_d    = is_signed & a[WIDTH-1];
          sb_d    = is_signed & b[WIDTH-1];
          zero_d  = (b == '0);
          quo_d   = neg_if(a, is_signed & a[WIDTH-1]);
          dvs_d   = neg_if(b, is_signed & b[WIDTH-1]);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!diff[WIDTH+1]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        // With b=0 the remainder magnitude is |a|, so the dividend-sign fix restores a exactly.
        q_d     = zero_q ? ALL_ONES : neg_if(quo_q, sa_q ^ sb_q);
        r_d     = neg_if(rem_q, sa_q);
        dz_d    = zero_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  // Working datapath registers, only meaningful while an operation runs
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    sa_q   <= sa_d;
    sb_q   <= sb_d;
    zero_q <= zero_d;
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on done.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] q, r;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: plain integer division, with the architectural corner cases spelled out.
  function automatic exp_t model(input logic sgn, input logic [31:0] x, input logic [31:0] y, input string tag);
    exp_t e;
    int sx, sy;
    e.tag = tag;
    e.dz  = 1'b0;
    if (y == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = x;
      e.dz = 1'b1;
    end else if (!sgn) begin
      e.q = x / y;
      e.r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      sx  = x;
      sy  = y;
      e.q = sx / sy;
      e.r = sx % sy;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.tag, "_q"}, q, e.q);
        chk({e.tag, "_r"}, r, e.r);
        chk({e.tag, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  // Drive a one-cycle start; returns after the accepting edge (+1).
  task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; is_signed = sgn; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
  endtask

  // Count cycles after the accepting edge until done shows up (bounded).
  task automatic wait_done(input string name);
    int k;
    k = 1;
    while (k <= 40) begin
      @(posedge clk); #1;
      if (done) break;
      k++;
    end
    chk({name, "_latency"}, k, 33);
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y, input string name);
    sb_q.push_back(model(sgn, x, y, name));
    issue(sgn, x, y);
    chk({name, "_busy_on"}, {31'd0, busy}, 32'd1);
    wait_done(name);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    rst = 1'b1;

    // Directed cases
    run_op(1'b0, 32'd100, 32'd7, "udiv_100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv_m7_2");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "sdiv_7_m2");
    run_op(1'b1, 32'h1234_5678, 32'd0, "sdiv_by0");
    run_op(1'b0, 32'h1234_5678, 32'd0, "udiv_by0");
    run_op(1'b0, 32'd50, 32'd5, "dz_clear");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
    run_op(1'b1, 32'h8000_0000, 32'd0, "sdiv_min_by0");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, "udiv_max_1");
    run_op(1'b0, 32'd5, 32'hFFFF_FFFF, "udiv_small_big");

    // Second start while busy is ignored; only one done follows
    sb_q.push_back(model(1'b0, 32'd100, 32'd7, "busy_start"));
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; is_signed = 1'b0; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    begin : wait_busy_start
      int k;
      k = 11;
      while (k <= 40) begin
        @(posedge clk); #1;
        if (done) break;
        k++;
      end
      chk("busy_start_latency", k, 33);
    end

    // Start during the done cycle is ignored
    start = 1'b1; is_signed = 1'b0; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_on_done_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("start_on_done_q_hold", q, 32'd14);
    chk("hold_r", r, 32'd2);

    // Reset mid-operation aborts with no done
    issue(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_q", q, 32'd0);
    chk("abort_r", r, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    run_op(1'b0, 32'd1000, 32'd3, "after_abort");

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      logic        sg;
      logic [31:0] x, y;
      sg = $urandom_range(0, 1);
      x  = $urandom;
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: y = $urandom;
      endcase
      run_op(sg, x, y, $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width. All values below assume WIDTH=32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 a  input  32  dividend (register rs value); sampled with start.
REQ-007 b  input  32  divisor (register rt value); sampled with start.
REQ-008 busy  output  1  operation in progress; the PC stalls while busy=1.
REQ-009 done  output  1  one-cycle pulse; q, r and div_zero are valid and newly updated.
REQ-010 q  output  32  quotient, routed to LO.
REQ-011 r  output  32  remainder, routed to HI.
REQ-012 div_zero  output  1  the last completed operation had b=0.

Function
REQ-013 The block SHALL implement the states IDLE, CALC and FIX.
REQ-014 IDLE with start=1 SHALL:
- latch is_signed, the sign of a, the sign of b and b==0;
- latch the magnitudes |a| and |b| (|x| only when is_signed=1, raw value otherwise);
- clear the partial remainder and the iteration counter;
- go to CALC.
REQ-015 busy SHALL be 1 in CALC and FIX and 0 in IDLE. busy SHALL go high in the cycle after start is accepted.
REQ-016 CALC SHALL perform one restoring radix-2 step per cycle:
- shift the remainder left and bring in the next dividend MSB;
- subtract the divisor magnitude with a 33-bit subtract;
- keep the difference if it is non-negative and shift 1 into the quotient; otherwise shift in 0.
REQ-017 The 5-bit iteration counter SHALL run 0..31. After step 31, the state SHALL go to FIX. Counter wrap SHALL NOT re-enter CALC.
REQ-018 FIX SHALL write q and r, pulse done=1 for exactly that cycle, and return to IDLE. busy is 0 in the next cycle.
REQ-019 Latency SHALL be fixed: start sampled at edge N; CALC on edges N+1..N+32; FIX outputs registered at edge N+33. busy is high for 33 cycles; done is high for 1 cycle.
REQ-020 Signed sign fix:
- q SHALL be negated iff sign(a) != sign(b);
- r SHALL be negated iff a is negative;
- r therefore carries the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield q=0x80000000, r=0 with no flag. The 32-bit magnitude arithmetic produces this naturally.
REQ-022 b=0, either signedness, SHALL yield q=0xFFFFFFFF, r=a (original value), div_zero=1. Latency SHALL be unchanged.
REQ-023 start while busy=1 SHALL be ignored, with no effect on state or latched operands.
REQ-024 start in the same cycle as the done pulse SHALL be ignored. start is accepted only when state=IDLE.
REQ-025 Between operations, q, r and div_zero SHALL hold their last values.
REQ-026 a, b and is_signed SHALL be don't-care except in the accepting cycle.

Reset
REQ-027 rst=0 at a rising edge SHALL force:
- state=IDLE, busy=0, done=0;
- q=0, r=0, div_zero=0;
- counter=0.
REQ-028 Reset during CALC or FIX SHALL abort the operation with no done pulse. A start on the first edge with rst=1 SHALL be accepted normally.
REQ-029 Reset SHALL have priority over start.

Verification
REQ-030 Unsigned: is_signed=0, a=100, b=7, start 1 cycle -> busy=1 for 33 cycles, then done pulse; q=14, r=2.
REQ-031 Signed: a=0xFFFFFFF9 (-7), b=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also a=7, b=0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
REQ-032 Divide by zero: a=0x12345678, b=0, signed and unsigned -> q=0xFFFFFFFF, r=0x12345678, div_zero=1, done at edge N+33. The next valid op clears div_zero.
REQ-033 Overflow: is_signed=1, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0, div_zero=0.
REQ-034 Start during busy: a second start with a=9, b=3 at cycle N+10 -> ignored; the first result is unchanged; exactly one done pulse.
REQ-035 Reset mid-op: rst=0 at cycle N+15 -> busy=0 and q=r=0 on the next cycle, no done. A new start after rst=1 completes in 33 cycles.
